// File: rtl/ocx_tlx_rsp_credit_fifo.sv
// First-word-fall-through response FIFO with per-entry credit return,
// almost-full threshold, sticky error flags, synchronous flush and peak monitor.
module ocx_tlx_rsp_credit_fifo #(
  parameter int DATA_WIDTH   = 59,
  parameter int ADDR_WIDTH   = 5,
  parameter int AFULL_THRESH = 28
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic                  flush,
  input  logic                  err_clear,
  output logic                  credit_return,
  output logic [ADDR_WIDTH:0]   entry_count,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   peak_count,
  output logic                  overflow_err,
  output logic                  underflow_err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int PW    = ADDR_WIDTH + 2;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL = CW'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count, r_peak;
  logic [PW-1:0]         r_pend;
  logic                  r_credit, r_ovf, r_unf;

  logic          w_pop, w_push, w_pop_credit, w_ovf_evt, w_unf_evt;
  logic [CW-1:0] w_count_next, w_peak_base, w_peak_next;
  logic [PW-1:0] w_flush_amt, w_pend_next;

  assign w_pop     = rd_valid & rd_ready;
  assign w_push    = wr_valid & ((r_count != C_DEPTH) | w_pop);
  assign w_ovf_evt = wr_valid & (r_count == C_DEPTH) & ~w_pop;
  assign w_unf_evt = rd_ready & (r_count == '0);

  always_comb begin
    w_count_next = r_count;
    if (flush)
      w_count_next = '0;
    else if (w_push & ~w_pop)
      w_count_next = r_count + 1'b1;
    else if (w_pop & ~w_push)
      w_count_next = r_count - 1'b1;
  end

  // Flushed entries and later pops share one pending-credit counter, drained one per cycle.
  assign w_pop_credit = w_pop & ~flush;
  assign w_flush_amt  = flush ? {1'b0, r_count} : '0;
  assign w_pend_next  = r_pend + {{(PW-1){1'b0}}, w_pop_credit} + w_flush_amt
                      - {{(PW-1){1'b0}}, r_credit};

  assign w_peak_base = err_clear ? r_count : r_peak;
  assign w_peak_next = (w_count_next > w_peak_base) ? w_count_next : w_peak_base;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_pend   <= '0;
      r_credit <= 1'b0;
      r_peak   <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count  <= w_count_next;
      r_pend   <= w_pend_next;
      r_credit <= (w_pend_next != '0);
      r_peak   <= w_peak_next;
      r_ovf    <= w_ovf_evt | (r_ovf & ~err_clear);
      r_unf    <= w_unf_evt | (r_unf & ~err_clear);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (w_push & ~flush & ~reset) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data       = r_mem[r_rd_ptr];
  assign rd_valid      = (r_count != '0);
  assign almost_full   = (r_count >= C_AFULL);
  assign entry_count   = r_count;
  assign peak_count    = r_peak;
  assign credit_return = r_credit;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;
endmodule

// File: tb/tb_ocx_tlx_rsp_credit_fifo.sv
// Randomized + directed bench for ocx_tlx_rsp_credit_fifo against a queue-based model.
module tb_ocx_tlx_rsp_credit_fifo;
  localparam int DW = 59;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam int AF = 28;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          flush = 1'b0;
  logic          err_clear = 1'b0;
  logic          credit_return;
  logic [AW:0]   entry_count;
  logic          almost_full;
  logic [AW:0]   peak_count;
  logic          overflow_err;
  logic          underflow_err;

  ocx_tlx_rsp_credit_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF)) dut (
    .clock(clock), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .flush(flush),
    .err_clear(err_clear), .credit_return(credit_return), .entry_count(entry_count),
    .almost_full(almost_full), .peak_count(peak_count), .overflow_err(overflow_err),
    .underflow_err(underflow_err));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: contents queue, owed credits, flags, peak.
  logic [DW-1:0] mq[$];
  bit m_ovf, m_unf, m_cr;
  int m_peak, m_owed;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit wv, input logic [DW-1:0] wd, input bit rr,
                            input bit fl, input bit ec, input bit rst);
    int n, removed, base;
    bit pop;
    if (rst) begin
      mq.delete(); m_ovf = 0; m_unf = 0; m_cr = 0; m_peak = 0; m_owed = 0;
      return;
    end
    n = mq.size();
    pop = (n > 0) && rr;
    removed = 0;
    if (wv && n == DEPTH && !pop) m_ovf = 1; else if (ec) m_ovf = 0;
    if (rr && n == 0) m_unf = 1; else if (ec) m_unf = 0;
    if (fl) begin
      removed = n;
      mq.delete();
    end else begin
      if (pop) begin void'(mq.pop_front()); removed = 1; end
      if (wv && (n < DEPTH || pop)) mq.push_back(wd);
    end
    // Every removed entry is owed exactly one pulse; pulses go out one per cycle.
    m_owed += removed;
    m_cr = (m_owed > 0);
    if (m_cr) m_owed--;
    base = ec ? n : m_peak;
    m_peak = (mq.size() > base) ? mq.size() : base;
  endtask

  always @(posedge clock) begin
    #2;
    if (chk_en) begin
      cmp("entry_count", 64'(entry_count), 64'(mq.size()));
      cmp("rd_valid", 64'(rd_valid), 64'(mq.size() > 0));
      cmp("almost_full", 64'(almost_full), 64'(mq.size() >= AF));
      cmp("credit_return", 64'(credit_return), 64'(m_cr));
      cmp("peak_count", 64'(peak_count), 64'(m_peak));
      cmp("overflow_err", 64'(overflow_err), 64'(m_ovf));
      cmp("underflow_err", 64'(underflow_err), 64'(m_unf));
      if (mq.size() > 0) cmp("rd_data", 64'(rd_data), 64'(mq[0]));
    end
  end

  int pc;
  int rises;
  bit prev_cr;

  // Drives one cycle; returns 1 time unit after the edge with the model updated.
  task automatic cyc(input bit wv, input logic [DW-1:0] wd, input bit rr,
                     input bit fl, input bit ec, input bit rst);
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl; err_clear = ec; reset = rst;
    @(posedge clock);
    model_step(wv, wd, rr, fl, ec, rst);
    #1;
    if (credit_return) pc++;
    if (credit_return && !prev_cr) rises++;
    prev_cr = credit_return;
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction

  localparam logic [DW-1:0] A = 59'h0A0A;
  localparam logic [DW-1:0] B = 59'h0B0B;
  localparam logic [DW-1:0] C = 59'h0C0C;

  initial begin
    cyc(0, '0, 0, 0, 0, 1);
    cyc(0, '0, 0, 0, 0, 1);
    chk_en = 1'b1;
    cmp("rst_count", 64'(entry_count), 64'd0);
    cmp("rst_rd_valid", 64'(rd_valid), 64'd0);
    cmp("rst_credit", 64'(credit_return), 64'd0);
    cmp("rst_flags", 64'({overflow_err, underflow_err, almost_full}), 64'd0);

    // Three pushes, head visible one cycle after the first.
    cyc(1, A, 0, 0, 0, 0);
    cmp("rd_valid_after_A", 64'(rd_valid), 64'd1);
    cyc(1, B, 0, 0, 0, 0);
    cyc(1, C, 0, 0, 0, 0);
    cmp("count3", 64'(entry_count), 64'd3);
    cmp("head_A", 64'(rd_data), 64'(A));

    // Fill to full, checking the almost-full threshold crossing.
    for (int k = 4; k <= DEPTH; k++) begin
      cyc(1, rnd(), 0, 0, 0, 0);
      if (k == AF - 1) cmp("af_below", 64'(almost_full), 64'd0);
      if (k == AF)     cmp("af_at", 64'(almost_full), 64'd1);
    end
    cmp("count_full", 64'(entry_count), 64'd32);
    cyc(1, rnd(), 0, 0, 0, 0);
    cmp("ovf_set", 64'(overflow_err), 64'd1);
    cmp("ovf_count", 64'(entry_count), 64'd32);
    cyc(0, '0, 0, 0, 1, 0);
    cmp("ovf_clear", 64'(overflow_err), 64'd0);
    cmp("peak_32", 64'(peak_count), 64'd32);

    // Full with simultaneous push and pop.
    cyc(1, 59'h0D0D, 1, 0, 0, 0);
    cmp("full_pp_count", 64'(entry_count), 64'd32);
    cmp("full_pp_head", 64'(rd_data), 64'(B));
    cmp("full_pp_credit", 64'(credit_return), 64'd1);
    cmp("ovf_not_set", 64'(overflow_err), 64'd0);
    cyc(0, '0, 0, 0, 0, 0);
    cmp("credit_one_pulse", 64'(credit_return), 64'd0);

    // Stream across the pointer wrap, then drain.
    for (int k = 0; k < 40; k++) cyc(1, rnd(), 1, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) cyc(0, '0, 1, 0, 0, 0);
    cmp("drained", 64'(entry_count), 64'd0);
    cyc(0, '0, 0, 0, 0, 0);

    // Underflow on empty.
    cyc(0, '0, 1, 0, 0, 0);
    cmp("unf_set", 64'(underflow_err), 64'd1);
    cyc(0, '0, 0, 0, 0, 0);
    cmp("unf_no_credit", 64'(credit_return), 64'd0);
    cyc(0, '0, 0, 0, 1, 0);
    cmp("unf_clear", 64'(underflow_err), 64'd0);

    // Flush five entries with a same-cycle push, then one pop two cycles later.
    for (int k = 0; k < 5; k++) cyc(1, rnd(), 0, 0, 0, 0);
    pc = 0; rises = 0; prev_cr = 0;
    cyc(1, rnd(), 0, 1, 0, 0);
    cmp("flush_count", 64'(entry_count), 64'd0);
    cmp("flush_rd_valid", 64'(rd_valid), 64'd0);
    cyc(1, 59'h1234, 0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, '0, 0, 0, 0, 0);
    cmp("flush_pulses", 64'(pc), 64'd6);
    cmp("flush_contig", 64'(rises), 64'd1);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0,
          $urandom_range(0, 40) == 0, $urandom_range(0, 15) == 0, 0);
    end
    for (int k = 0; k < 300; k++) begin
      cyc($urandom_range(0, 1) == 0, rnd(), $urandom_range(0, 4) == 0,
          $urandom_range(0, 60) == 0, $urandom_range(0, 30) == 0, 0);
    end

    // Reset mid-drain with credits pending.
    cyc(0, '0, 0, 0, 1, 1);
    for (int k = 0; k < 10; k++) cyc(1, rnd(), 0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 1, 1, 0, 0);
    cyc(0, '0, 0, 0, 0, 0);
    cmp("pending_before_rst", 64'(credit_return), 64'd1);
    cyc(0, '0, 0, 0, 0, 1);
    cmp("midrst_count", 64'(entry_count), 64'd0);
    cmp("midrst_credit", 64'(credit_return), 64'd0);
    cmp("midrst_peak", 64'(peak_count), 64'd0);
    pc = 0;
    for (int k = 0; k < 12; k++) cyc(0, '0, 0, 0, 0, 0);
    cmp("no_pulse_after_rst", 64'(pc), 64'd0);

    @(posedge clock); #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ocx_tlx_rsp_credit_fifo.md
Name: ocx_tlx_rsp_credit_fifo

Overview:
Parametrised, first-word-fall-through response FIFO for the TLX framer response path. It generalises the fixed 59-bit x 32-entry response FIFO in four ways:
- valid/ready pop handshake;
- per-entry credit return to the upstream producer;
- programmable almost-full threshold;
- sticky error flags with clear, a synchronous flush and a peak-occupancy monitor.

It sits between the TLX response generators and the framer's response-slot packer.

Parameters:
DATA_WIDTH, 59, width of one response entry
ADDR_WIDTH, 5, pointer width; depth DEPTH = 2**ADDR_WIDTH (derived localparam, not overridable)
AFULL_THRESH, 28, almost_full asserts when entry_count >= AFULL_THRESH; legal range 1..DEPTH

Ports:
clock  input  1  sole clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
wr_data  input  DATA_WIDTH  push data
wr_valid  input  1  push request; no ready, producer is credit-managed
rd_data  output  DATA_WIDTH  head entry, valid when rd_valid=1
rd_valid  output  1  FIFO non-empty
rd_ready  input  1  consumer accepts head; pop = rd_valid & rd_ready
flush  input  1  synchronous discard of all contents
err_clear  input  1  clears sticky error flags
credit_return  output  1  one-cycle pulse per popped entry, registered
entry_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
almost_full  output  1  entry_count >= AFULL_THRESH
peak_count  output  ADDR_WIDTH+1  highest occupancy since reset/err_clear
overflow_err  output  1  sticky: push dropped while full
underflow_err  output  1  sticky: rd_ready asserted while empty

Behaviour:
- Reset (highest priority):
  - pointers and entry_count = 0; credit_return = 0, peak_count = 0, both error flags = 0.
  - Hence rd_valid = 0 and almost_full = 0.
  - Storage contents are not reset.
- Storage:
  - Distributed register array of DEPTH x DATA_WIDTH.
  - rd_data is a combinational read at rd_ptr; its value is don't-care when rd_valid = 0.
- Push (effective push): wr_valid & (entry_count < DEPTH | pop).
  - Writes at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- Pop: rd_valid & rd_ready. rd_ptr increments modulo DEPTH.
- Latency:
  - A push in cycle N is visible at the head (rd_valid = 1) in cycle N+1.
  - There is no same-cycle empty bypass.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
  - Full with simultaneous pop and push: both are accepted and the count stays DEPTH.
- Overflow:
  - Condition: wr_valid while entry_count == DEPTH and no pop in the same cycle.
  - The write is dropped; pointers and count are unchanged; overflow_err is set at the next edge.
- Underflow:
  - Condition: rd_ready while entry_count == 0.
  - No pointer change; underflow_err is set at the next edge.
- Error flags stay set until reset or err_clear.
  - err_clear in the same cycle as a new error event: the set wins.
  - err_clear also loads peak_count with the current entry_count.
- credit_return:
  - Registered copy of pop: it pulses in cycle N+1 for a pop in cycle N.
  - Back-to-back pops produce a continuous high.
  - Flush returns credits one per cycle for each discarded entry (see flush below).
- flush (lower priority than reset):
  - At the edge: rd_ptr <= wr_ptr and entry_count <= 0. Any push or pop in the flush cycle is ignored.
  - A flush-credit counter loads the discarded count. It then drives credit_return high for that many consecutive cycles.
  - If pops occur afterwards, their credits are queued behind the flush credits in the same counter, so no credit is ever lost.
  - Total credit pulses always equal total entries removed.
  - Counter width: ADDR_WIDTH+2, because it can never exceed DEPTH plus in-flight credits.
- Credit counter model:
  - credit_pending <= credit_pending + pop + flush_amount - (credit_pending != 0).
  - credit_return = (credit_pending != 0), registered.
  - With no flush this reduces to the registered pop pulse.
- peak_count updates to entry_count_next whenever that value is larger. It saturates at DEPTH.
- almost_full and rd_valid are decoded from registered entry_count (glitch-free, no combinational path from wr_valid).
- A reset mid-operation discards everything, including pending credits. The upstream credit pool is re-initialised by its own reset.

Test Plan:
- Reset then 3 pushes (A,B,C) with rd_ready = 0 → rd_valid rises the cycle after A; entry_count = 3; rd_data = A.
- 32 pushes with no pop → entry_count = 32 and almost_full from the 28th push. A 33rd push → dropped, overflow_err = 1, count stays 32. err_clear → overflow_err = 0, peak_count = 32.
- Full FIFO, simultaneous push D and pop → count stays 32, the next head is entry 2, credit_return pulses one cycle later. Drain 40 pushes/pops across the wrap → data order preserved.
- rd_ready = 1 while empty → underflow_err = 1, pointers unchanged, no credit_return.
- 5 entries held, assert flush plus wr_valid in the same cycle → entry_count = 0, rd_valid = 0, credit_return high 5 consecutive cycles. A pop 2 cycles later → 6 total pulses, still contiguous.
- Reset asserted mid-drain with credits pending → all outputs return to reset values the next cycle and no further credit_return pulses occur.
